// File: rtl/bubble_sort_engine.sv
// Bubble sort engine: in-place sort of a DEPTH x WIDTH register array.
// The array is loaded and read through dedicated ports while idle. A sort walks
// adjacent pairs one pass at a time and stops early once a pass makes no swap.
// Order (ascending/descending) and signedness are captured when start is accepted.
module bubble_sort_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             desc,
    input  logic             sgn,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic [15:0]      swaps,
    output logic [AW-1:0]    passes
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_CMP      = 3'd2,
        S_SWAP     = 3'd3,
        S_PASS_END = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    // Highest pair index of the first pass, and the index of the final pass.
    localparam logic [AW-1:0] ONE_AW = AW'(1);
    localparam logic [AW-1:0] P_LAST = AW'(DEPTH - 2);

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [AW-1:0]      j_r;
    logic [AW-1:0]      p_r;
    logic [AW-1:0]      j_next_idx_s;
    logic [AW-1:0]      last_j_s;
    logic               flag_r;
    logic               desc_r;
    logic               sgn_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               a_gt_b_s;
    logic               a_lt_b_s;
    logic               need_swap_s;
    logic               more_pairs_s;
    logic [15:0]        swaps_r;
    logic [AW-1:0]      passes_r;
    logic               busy_r;
    logic               done_r;

    // Each pass bubbles one element into place, so the pair range shrinks by one per pass.
    assign j_next_idx_s = j_r + ONE_AW;
    assign last_j_s     = P_LAST - p_r;
    assign more_pairs_s = (j_r < last_j_s);

    assign rd_data = mem_r[rd_addr];
    assign busy    = busy_r;
    assign done    = done_r;
    assign swaps   = swaps_r;
    assign passes  = passes_r;

    // Strict compare of the latched pair in the latched signedness; equal values never swap.
    always_comb begin
        a_gt_b_s    = 1'b0;
        a_lt_b_s    = 1'b0;
        need_swap_s = 1'b0;
        if (sgn_r) begin
            a_gt_b_s = ($signed(a_r) > $signed(b_r));
            a_lt_b_s = ($signed(a_r) < $signed(b_r));
        end else begin
            a_gt_b_s = (a_r > b_r);
            a_lt_b_s = (a_r < b_r);
        end
        if (desc_r) begin
            need_swap_s = a_lt_b_s;
        end else begin
            need_swap_s = a_gt_b_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_READ;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_READ: begin
                state_next_s = S_CMP;
            end
            S_CMP: begin
                if (need_swap_s) begin
                    state_next_s = S_SWAP;
                end else if (more_pairs_s) begin
                    state_next_s = S_READ;
                end else begin
                    state_next_s = S_PASS_END;
                end
            end
            S_SWAP: begin
                if (more_pairs_s) begin
                    state_next_s = S_READ;
                end else begin
                    state_next_s = S_PASS_END;
                end
            end
            S_PASS_END: begin
                if (!flag_r || (p_r == P_LAST)) begin
                    state_next_s = S_FINISH;
                end else begin
                    state_next_s = S_READ;
                end
            end
            S_FINISH: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Status outputs registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != S_IDLE);
            done_r <= (state_next_s == S_FINISH);
        end
    end

    // Sort bookkeeping: pair index, pass index, swap flag, counters and latched operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j_r      <= '0;
            p_r      <= '0;
            flag_r   <= 1'b0;
            desc_r   <= 1'b0;
            sgn_r    <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            swaps_r  <= 16'd0;
            passes_r <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        j_r      <= '0;
                        p_r      <= '0;
                        flag_r   <= 1'b0;
                        desc_r   <= desc;
                        sgn_r    <= sgn;
                        swaps_r  <= 16'd0;
                        passes_r <= '0;
                    end
                end
                S_READ: begin
                    a_r <= mem_r[j_r];
                    b_r <= mem_r[j_next_idx_s];
                end
                S_CMP: begin
                    if (!need_swap_s && more_pairs_s) begin
                        j_r <= j_next_idx_s;
                    end
                end
                S_SWAP: begin
                    if (swaps_r != 16'hFFFF) begin
                        swaps_r <= swaps_r + 16'd1;
                    end
                    flag_r <= 1'b1;
                    if (more_pairs_s) begin
                        j_r <= j_next_idx_s;
                    end
                end
                S_PASS_END: begin
                    passes_r <= passes_r + ONE_AW;
                    if (flag_r && (p_r != P_LAST)) begin
                        p_r    <= p_r + ONE_AW;
                        j_r    <= '0;
                        flag_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Array storage: host loads only while idle; the pair is exchanged on a single edge in SWAP.
    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if ((state_r == S_IDLE) && ld_en) begin
            mem_r[ld_addr] <= ld_data;
        end else if (state_r == S_SWAP) begin
            mem_r[j_r]          <= b_r;
            mem_r[j_next_idx_s] <= a_r;
        end
    end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Testbench for bubble_sort_engine (DEPTH=4, WIDTH=8): directed vectors plus
// randomized sorts checked against an array-level reference model.
module tb_bubble_sort_engine;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic             desc;
    logic             sgn;
    logic             ld_en;
    logic [AW-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;
    logic [15:0]      swaps;
    logic [AW-1:0]    passes;

    int n_checks;
    int n_fail;

    logic [WIDTH-1:0] ref_arr [DEPTH];

    bubble_sort_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .desc    (desc),
        .sgn     (sgn),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .swaps   (swaps),
        .passes  (passes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_num(input logic [WIDTH-1:0] v, input logic s);
        if (s && v[WIDTH-1]) return int'(v) - (1 << WIDTH);
        return int'(v);
    endfunction

    // Reference: textbook bubble sort with early exit, counting work done.
    task automatic model_sort(input logic d, input logic s, output int comps,
                              output int nsw, output int npass);
        logic [WIDTH-1:0] t;
        bit swapped;
        comps = 0; nsw = 0; npass = 0;
        for (int p = 0; p <= DEPTH - 2; p++) begin
            swapped = 1'b0;
            for (int j = 0; j <= DEPTH - 2 - p; j++) begin
                int x, y;
                x = to_num(ref_arr[j], s);
                y = to_num(ref_arr[j+1], s);
                comps++;
                if (d ? (x < y) : (x > y)) begin
                    t = ref_arr[j]; ref_arr[j] = ref_arr[j+1]; ref_arr[j+1] = t;
                    nsw++;
                    swapped = 1'b1;
                end
            end
            npass++;
            if (!swapped) break;
        end
    endtask

    task automatic load_all(input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] v1,
                            input logic [WIDTH-1:0] v2, input logic [WIDTH-1:0] v3);
        logic [WIDTH-1:0] v [DEPTH];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = AW'(i); ld_data = v[i];
            ref_arr[i] = v[i];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_model_arr(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            rd_addr = AW'(i);
            #1;
            check($sformatf("%s_arr%0d", tag, i), 32'(rd_data), 32'(ref_arr[i]));
        end
    endtask

    task automatic check_const_arr(input string tag, input logic [31:0] packed_exp);
        logic [31:0] e;
        e = packed_exp;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            rd_addr = AW'(i);
            #1;
            check($sformatf("%s_const%0d", tag, i), 32'(rd_data), 32'(e[8*i +: 8]));
        end
    endtask

    // Run one sort on the current array and check latency, counters and result.
    task automatic do_sort(input string tag, input logic d, input logic s, input bit inject);
        int comps, nsw, npass, lat, cyc;
        model_sort(d, s, comps, nsw, npass);
        lat = 2 * comps + nsw + npass + 1;
        @(negedge clk);
        start = 1'b1; desc = d; sgn = s;
        @(posedge clk);
        #1;
        start = 1'b0; desc = ~d; sgn = ~s;
        cyc = 1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && cyc < 400) begin
            if (inject && cyc == 3) begin
                ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'hAA; start = 1'b1;
            end
            @(posedge clk);
            #1;
            ld_en = 1'b0; start = 1'b0;
            cyc++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_swaps"}, 32'(swaps), 32'(nsw));
        check({tag, "_passes"}, 32'(passes), 32'(npass));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_no_restart"}, 32'(busy | done), 32'd0);
        check({tag, "_swaps_hold"}, 32'(swaps), 32'(nsw));
        check_model_arr(tag);
    endtask

    initial begin
        int cnt;
        n_checks = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; desc = 1'b0; sgn = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_swaps", 32'(swaps), 32'd0);
        check("reset_passes", 32'(passes), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        load_all(8'd1, 8'd2, 8'd3, 8'd4);
        do_sort("sorted", 1'b0, 1'b0, 1'b0);
        check_const_arr("sorted", 32'h04030201);

        load_all(8'd4, 8'd3, 8'd2, 8'd1);
        do_sort("reverse", 1'b0, 1'b0, 1'b0);
        check_const_arr("reverse", 32'h04030201);
        check("reverse_swaps6", 32'(swaps), 32'd6);

        load_all(8'h80, 8'h7F, 8'h00, 8'hFF);
        do_sort("signed", 1'b0, 1'b1, 1'b0);
        check_const_arr("signed", 32'h7F00FF80);

        load_all(8'h80, 8'h7F, 8'h00, 8'hFF);
        do_sort("unsigned", 1'b0, 1'b0, 1'b0);
        check_const_arr("unsigned", 32'hFF807F00);

        load_all(8'd2, 8'd2, 8'd1, 8'd3);
        do_sort("equal_desc", 1'b1, 1'b0, 1'b0);
        check_const_arr("equal_desc", 32'h01020203);
        check("equal_desc_swaps3", 32'(swaps), 32'd3);

        // Reset during the 5th cycle of a reverse sort.
        load_all(8'd4, 8'd3, 8'd2, 8'd1);
        @(negedge clk);
        start = 1'b1; desc = 1'b0; sgn = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_swaps", 32'(swaps), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            rd_addr = AW'(i);
            #1;
            ref_arr[i] = rd_data;
        end
        for (int v = 1; v <= DEPTH; v++) begin
            cnt = 0;
            for (int i = 0; i < DEPTH; i++) if (int'(ref_arr[i]) == v) cnt++;
            check($sformatf("midrst_perm%0d", v), 32'(cnt), 32'd1);
        end
        do_sort("after_rst", 1'b0, 1'b0, 1'b0);
        check_const_arr("after_rst", 32'h04030201);

        // Load and start while busy must be ignored.
        load_all(8'd9, 8'd7, 8'd5, 8'd3);
        do_sort("busy_ignore", 1'b0, 1'b0, 1'b1);

        // Randomized sorts, small value range so equal elements occur.
        for (int n = 0; n < 30; n++) begin
            logic [WIDTH-1:0] r0, r1, r2, r3;
            if (n % 2 == 0) begin
                r0 = WIDTH'($urandom_range(0, 5)); r1 = WIDTH'($urandom_range(0, 5));
                r2 = WIDTH'($urandom_range(0, 5)); r3 = WIDTH'($urandom_range(0, 5));
            end else begin
                r0 = WIDTH'($urandom); r1 = WIDTH'($urandom);
                r2 = WIDTH'($urandom); r3 = WIDTH'($urandom);
            end
            load_all(r0, r1, r2, r3);
            do_sort($sformatf("rand%0d", n), 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
